// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: freezes on I/D misses, one load-use bubble, redirect flush.
// Latency: outputs combinational from inputs + flags. Backpressure: any unmet cache side zeroes every load enable.
// Optional perf counters built when HAZARD_PERF_EN is defined; otherwise perf ports read zero.
module hazard_stall_ctrl #(
    parameter int REG_W  = 5,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_req,
    input  logic              imem_resp,
    input  logic              dmem_req,
    input  logic              dmem_resp,
    input  logic              ex_is_load,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_br_taken,
    output logic [4:0]        stall_load,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [PERF_W-1:0] perf_mem_stall,
    output logic [PERF_W-1:0] perf_lu_bubble,
    output logic [PERF_W-1:0] perf_flush
);

    typedef enum logic {RUN, MISS} state_t;

    state_t state;
    logic   i_done, d_done, lu_q;
    logic   i_ok, d_ok, advance, lu_hit, bubble, redirect;

    always_comb begin
        i_ok     = !imem_req | imem_resp | i_done;
        d_ok     = !dmem_req | dmem_resp | d_done;
        advance  = i_ok & d_ok;
        redirect = advance & ex_br_taken;
        // lu_q masks the cycle after a bubble: ID/EX then holds the NOP, not the load
        lu_hit   = ex_is_load & (ex_rd != '0) & !lu_q &
                   ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
        bubble   = advance & !ex_br_taken & lu_hit;

        stall_load  = 5'b00000;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (rst || !advance) begin
            stall_load = 5'b00000;
        end else if (ex_br_taken) begin
            stall_load  = 5'b11111;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (lu_hit) begin
            stall_load  = 5'b00111;
            flush_id_ex = 1'b1;
        end else begin
            stall_load = 5'b11111;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            i_done <= 1'b0;
            d_done <= 1'b0;
            lu_q   <= 1'b0;
        end else if (advance) begin
            state  <= RUN;
            i_done <= 1'b0;
            d_done <= 1'b0;
            lu_q   <= bubble;
        end else begin
            state <= MISS;
            if (imem_req && imem_resp) i_done <= 1'b1;
            if (dmem_req && dmem_resp) d_done <= 1'b1;
        end
    end

    // Done flags can only be pending while a miss is being waited out
    always_ff @(posedge clk) begin
        if (!rst && state == RUN) begin
            assert (!i_done && !d_done) else $error("done flag set while in RUN");
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_mem_stall <= '0;
            perf_lu_bubble <= '0;
            perf_flush     <= '0;
        end else begin
            if (!advance && perf_mem_stall != '1) perf_mem_stall <= perf_mem_stall + 1'b1;
            if (bubble   && perf_lu_bubble != '1) perf_lu_bubble <= perf_lu_bubble + 1'b1;
            if (redirect && perf_flush     != '1) perf_flush     <= perf_flush + 1'b1;
        end
    end
`else
    assign perf_mem_stall = '0;
    assign perf_lu_bubble = '0;
    assign perf_flush     = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; perf expectations follow HAZARD_PERF_EN.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_resp, dmem_req, dmem_resp;
    logic        ex_is_load, id_use_rs1, id_use_rs2, ex_br_taken;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic [4:0]  stall_load;
    logic        flush_if_id, flush_id_ex;
    logic [31:0] perf_mem_stall, perf_lu_bubble, perf_flush;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_W(5), .PERF_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_resp      (imem_resp),
        .dmem_req       (dmem_req),
        .dmem_resp      (dmem_resp),
        .ex_is_load     (ex_is_load),
        .ex_rd          (ex_rd),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .ex_br_taken    (ex_br_taken),
        .stall_load     (stall_load),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .perf_mem_stall (perf_mem_stall),
        .perf_lu_bubble (perf_lu_bubble),
        .perf_flush     (perf_flush)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge, then let new inputs settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
        ex_is_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_br_taken = 0;
    endtask

    task automatic chk_out(input string tag, input logic [4:0] sl, input logic fi, input logic fe);
        #2;
        chk({tag, ".stall_load"}, 32'(stall_load), 32'(sl));
        chk({tag, ".flush_if_id"}, 32'(flush_if_id), 32'(fi));
        chk({tag, ".flush_id_ex"}, 32'(flush_id_ex), 32'(fe));
    endtask

    task automatic chk_perf(input string tag, input int ms, input int lu, input int fl);
`ifdef HAZARD_PERF_EN
        chk({tag, ".perf_mem_stall"}, perf_mem_stall, 32'(ms));
        chk({tag, ".perf_lu_bubble"}, perf_lu_bubble, 32'(lu));
        chk({tag, ".perf_flush"},     perf_flush,     32'(fl));
`else
        chk({tag, ".perf_mem_stall"}, perf_mem_stall, 32'd0);
        chk({tag, ".perf_lu_bubble"}, perf_lu_bubble, 32'd0);
        chk({tag, ".perf_flush"},     perf_flush,     32'd0);
`endif
    endtask

    initial begin
        clear_in();
        rst = 1;
        tick();
        tick();
        chk_out("reset", 5'b00000, 0, 0);
        chk_perf("reset", 0, 0, 0);
        chk("reset.state", 32'(dut.state), 32'd0);
        rst = 0;

        // Idle fetch answered every cycle: never stalls
        for (int c = 0; c < 3; c++) begin
            imem_req = 1; imem_resp = 1;
            chk_out("idle_fetch", 5'b11111, 0, 0);
            chk("idle_fetch.state", 32'(dut.state), 32'd0);
            tick();
        end
        clear_in();

        // Split miss: I resp at cycle 3 remembered until D resp at cycle 6
        for (int c = 0; c < 8; c++) begin
            imem_req  = (c <= 6);
            dmem_req  = (c <= 6);
            imem_resp = (c == 3);
            dmem_resp = (c == 6);
            chk_out($sformatf("split_c%0d", c), (c == 6 || c == 7) ? 5'b11111 : 5'b00000, 0, 0);
            chk($sformatf("split_c%0d.i_done", c), 32'(dut.i_done), 32'((c >= 4 && c <= 6)));
            tick();
        end
        clear_in();

        // Resp pulse with its request low must not set a done flag
        imem_req = 1; dmem_resp = 1;
        chk_out("stray_dresp", 5'b00000, 0, 0);
        tick();
        dmem_resp = 0;
        #2;
        chk("stray_dresp.d_done", 32'(dut.d_done), 32'd0);
        clear_in();
        tick();

        // Load-use on rs2: one bubble, then the pipe moves on
        ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        chk_out("lu_rs2_bubble", 5'b00111, 0, 1);
        tick();
        chk_out("lu_rs2_after", 5'b11111, 0, 0);
        tick();
        clear_in();
        tick();

        // Load-use on rs1, and the same match with the use flag low
        ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
        chk_out("lu_rs1_bubble", 5'b00111, 0, 1);
        tick();
        clear_in();
        tick();
        ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0;
        chk_out("lu_rs1_unused", 5'b11111, 0, 0);
        tick();

        // x0 destination never creates a hazard
        clear_in();
        ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        chk_out("lu_x0", 5'b11111, 0, 0);
        tick();

        // Redirect overrides load-use; D-miss overrides redirect
        clear_in();
        ex_is_load = 1; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1; ex_br_taken = 1;
        chk_out("redirect_over_lu", 5'b11111, 1, 1);
        tick();
        dmem_req = 1;
        chk_out("dmiss_over_redirect", 5'b00000, 0, 0);
        tick();
        clear_in();
        tick();

        // Perf counters: 4-cycle miss, one bubble, two redirects
        rst = 1;
        tick();
        rst = 0;
        for (int c = 0; c < 5; c++) begin
            dmem_req = 1; dmem_resp = (c == 4);
            tick();
        end
        clear_in();
        ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
        tick();
        clear_in();
        tick();
        ex_br_taken = 1;
        tick();
        ex_br_taken = 0;
        tick();
        ex_br_taken = 1;
        tick();
        clear_in();
        #2;
        chk_perf("perf_run", 4, 1, 2);

        // Reset mid-miss drops a latched D response and clears counters
        imem_req = 1; dmem_req = 1; dmem_resp = 1;
        tick();
        dmem_resp = 0;
        #2;
        chk("midmiss.d_done_latched", 32'(dut.d_done), 32'd1);
        tick();
        rst = 1;
        tick();
        chk_out("midmiss_rst", 5'b00000, 0, 0);
        chk_perf("midmiss_rst", 0, 0, 0);
        chk("midmiss_rst.state", 32'(dut.state), 32'd0);
        chk("midmiss_rst.d_done", 32'(dut.d_done), 32'd0);
        rst = 0;
        clear_in();
        tick();
        chk_out("post_rst", 5'b11111, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
